// File: rtl/fit_scheduler.sv
// Fitness scheduler: issues one evaluation per gene, tracks the best result, stops on a TARGET hit.
// Per gene: ISSUE, WAIT (until fitnessReady or TIMEOUT cycles), CHECK, NEXT; leaves to IDLE when deselected.
module fit_scheduler #(
  parameter int POPULATION = 24,
  parameter int FIT_W = 10,
  parameter int TARGET = 2,
  parameter int TIMEOUT = 255,
  parameter logic [2:0] FIT_CTRL = 3'b001
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [2:0]       state_controller,
  input  logic [FIT_W-1:0] fitness,
  input  logic             fitnessReady,
  output logic             eval_start,
  output logic [7:0]       eval_index,
  output logic [FIT_W-1:0] best_fitness,
  output logic [7:0]       best_index,
  output logic             gene_found,
  output logic [7:0]       found_index,
  output logic             sched_done,
  output logic             timeout_flag,
  output logic [7:0]       eval_count,
  output logic [2:0]       state_sched
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    ISSUE = 3'b001,
    WAIT  = 3'b010,
    CHECK = 3'b011,
    NEXT  = 3'b100,
    DONE  = 3'b101,
    FOUND = 3'b110
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]       LAST_IDX = 8'(POPULATION - 1);
  localparam logic [FIT_W-1:0] TGT      = FIT_W'(TARGET);

  state_t           state;
  logic [TW-1:0]    timer;
  logic [FIT_W-1:0] fit_q;
  logic             active;

  assign active      = (state_controller == FIT_CTRL);
  assign state_sched = state;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      fit_q        <= '0;
      eval_start   <= 1'b0;
      eval_index   <= '0;
      best_fitness <= '0;
      best_index   <= '0;
      gene_found   <= 1'b0;
      found_index  <= '0;
      sched_done   <= 1'b0;
      timeout_flag <= 1'b0;
      eval_count   <= '0;
    end else begin
      eval_start <= 1'b0;
      // Losing the controller abandons the pass but keeps results visible.
      if (state != IDLE && !active) begin
        state      <= IDLE;
        gene_found <= 1'b0;
        sched_done <= 1'b0;
      end else begin
        case (state)
          IDLE: if (active) begin
            state        <= ISSUE;
            eval_start   <= 1'b1;
            eval_index   <= '0;
            best_fitness <= '0;
            best_index   <= '0;
            eval_count   <= '0;
            timeout_flag <= 1'b0;
            timer        <= '0;
          end
          ISSUE: begin
            timer <= '0;
            state <= WAIT;
          end
          WAIT: begin
            if (fitnessReady) begin
              fit_q <= fitness;
              state <= CHECK;
            end else if (timer == TMO_LAST) begin
              fit_q        <= '0;
              timeout_flag <= 1'b1;
              state        <= CHECK;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          CHECK: begin
            // Strict compare: ties keep the earlier index.
            if (fit_q > best_fitness) begin
              best_fitness <= fit_q;
              best_index   <= eval_index;
            end
            if (fit_q == TGT) begin
              gene_found  <= 1'b1;
              found_index <= eval_index;
              state       <= FOUND;
            end else begin
              state <= NEXT;
            end
          end
          NEXT: begin
            eval_count <= eval_count + 1'b1;
            if (eval_index == LAST_IDX) begin
              sched_done <= 1'b1;
              state      <= DONE;
            end else begin
              eval_index <= eval_index + 1'b1;
              eval_start <= 1'b1;
              state      <= ISSUE;
            end
          end
          DONE:    sched_done <= 1'b1;
          FOUND:   gene_found <= 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fit_scheduler.sv
// Bench for fit_scheduler: each pass is planned (fitness and response latency per gene) and the
// expected per-cycle outputs are derived from the plan as a timeline, then compared every cycle.
module tb_fit_scheduler;

  localparam int POP = 4;
  localparam int TGT = 10;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] ctrl;
  logic [9:0] fitness;
  logic       fit_rdy;
  logic       eval_start;
  logic [7:0] eval_index;
  logic [9:0] best_fitness;
  logic [7:0] best_index;
  logic       gene_found;
  logic [7:0] found_index;
  logic       sched_done;
  logic       timeout_flag;
  logic [7:0] eval_count;
  logic [2:0] state_sched;

  always #5 clk = ~clk;

  fit_scheduler #(
    .POPULATION(POP), .FIT_W(10), .TARGET(TGT), .TIMEOUT(TMO), .FIT_CTRL(3'b001)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .state_controller(ctrl), .fitness(fitness),
    .fitnessReady(fit_rdy), .eval_start(eval_start), .eval_index(eval_index),
    .best_fitness(best_fitness), .best_index(best_index), .gene_found(gene_found),
    .found_index(found_index), .sched_done(sched_done), .timeout_flag(timeout_flag),
    .eval_count(eval_count), .state_sched(state_sched)
  );

  typedef struct {
    logic [2:0] st;
    int idx, start, bf, bi, cnt, tf, gf, fi, dn, rdy, fv;
  } exp_t;

  exp_t tab[$];
  exp_t ex_q;
  exp_t last;
  int   fit[POP];
  int   lat[POP];
  int   m_fi = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   pulses = 0;
  bit   chk_en = 1'b0;

  function automatic void chk(string nm, int act, int exv);
    n_cmp++;
    if (act != exv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exv, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state_sched", int'(state_sched), int'(ex_q.st));
      chk("eval_start", int'(eval_start), ex_q.start);
      chk("eval_index", int'(eval_index), ex_q.idx);
      chk("best_fitness", int'(best_fitness), ex_q.bf);
      chk("best_index", int'(best_index), ex_q.bi);
      chk("gene_found", int'(gene_found), ex_q.gf);
      chk("found_index", int'(found_index), ex_q.fi);
      chk("sched_done", int'(sched_done), ex_q.dn);
      chk("timeout_flag", int'(timeout_flag), ex_q.tf);
      chk("eval_count", int'(eval_count), ex_q.cnt);
      if (eval_start) pulses++;
    end
  end

  // Expected output timeline of one pass: gene i occupies ISSUE, w WAIT cycles, CHECK, NEXT.
  function automatic void build();
    int bf = 0;
    int bi = 0;
    int tf = 0;
    exp_t e;
    tab.delete();
    for (int i = 0; i < POP; i++) begin
      int w  = (lat[i] <= TMO) ? lat[i] : TMO;
      int fe = (lat[i] <= TMO) ? fit[i] : 0;
      for (int o = 0; o <= w + 2; o++) begin
        e = '{default:0};
        e.idx = i; e.cnt = i; e.bf = bf; e.bi = bi; e.tf = tf; e.fi = m_fi;
        if (o == 0) begin
          e.st = 3'd1; e.start = 1;
        end else if (o <= w) begin
          e.st = 3'd2; e.rdy = (o == lat[i]) ? 1 : 0; e.fv = fit[i];
        end else begin
          if (lat[i] > TMO) e.tf = 1;
          if (o == w + 2) begin
            tf = e.tf;
            if (fe > bf) begin bf = fe; bi = i; end
            e.bf = bf; e.bi = bi;
            if (fe == TGT) begin
              e.st = 3'd6; e.gf = 1; e.fi = i;
              tab.push_back(e);
              return;
            end
            e.st = 3'd4;
          end else begin
            e.st = 3'd3;
          end
        end
        tab.push_back(e);
      end
    end
    e = '{default:0};
    e.st = 3'd5; e.idx = POP - 1; e.cnt = POP; e.bf = bf; e.bi = bi; e.tf = tf; e.fi = m_fi; e.dn = 1;
    tab.push_back(e);
  endfunction

  task automatic leave(input bit rst);
    if (rst) reset = 1'b1;
    else ctrl = 3'b000;
    @(posedge clk); #1;
    if (rst) begin
      ex_q = '{default:0};
      m_fi = 0;
    end else begin
      ex_q = last;
      ex_q.st = 3'd0; ex_q.start = 0; ex_q.gf = 0; ex_q.dn = 0;
      m_fi = last.fi;
    end
    reset = 1'b0;
    ctrl  = 3'b000;
    fitness = 10'(TGT);
    fit_rdy = 1'($urandom_range(0, 1));
    repeat ($urandom_range(1, 3)) begin
      @(posedge clk); #1;
      fit_rdy = 1'($urandom_range(0, 1));
    end
    fit_rdy = 1'b0;
  endtask

  // abort_at < 0: run to the terminal state plus two hold cycles and return still selected.
  task automatic run_pass(input int abort_at, input bit rst);
    int n;
    int stop;
    exp_t cur;
    build();
    n = tab.size();
    stop = (abort_at >= 0) ? abort_at : n + 1;
    ctrl = 3'b001;
    pulses = 0;
    for (int k = 0; k <= stop; k++) begin
      @(posedge clk); #1;
      cur = tab[(k < n) ? k : n - 1];
      ex_q = cur;
      if (cur.st == 3'd2) begin
        fit_rdy = 1'(cur.rdy);
        fitness = cur.rdy != 0 ? 10'(cur.fv) : 10'($urandom_range(0, 1023));
      end else begin
        // Strobes outside WAIT carry the target value and must be ignored.
        fit_rdy = ($urandom_range(0, 2) == 0);
        fitness = 10'(TGT);
      end
    end
    last = tab[(stop < n) ? stop : n - 1];
    if (abort_at >= 0) leave(rst);
  endtask

  task automatic plan(input int f0, f1, f2, f3, input int l0, l1, l2, l3);
    fit[0] = f0; fit[1] = f1; fit[2] = f2; fit[3] = f3;
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
  endtask

  initial begin
    reset = 1'b1;
    ctrl = 3'b001;
    fitness = '0;
    fit_rdy = 1'b1;
    ex_q = '{default:0};
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    ctrl = 3'b000;
    reset = 1'b0;
    fit_rdy = 1'b0;
    @(posedge clk); #1;

    // Plain pass, every gene answers two cycles after its start pulse.
    plan(3, 7, 5, 2, 2, 2, 2, 2);
    run_pass(-1, 1'b0);
    chk("lit_done", int'(sched_done), 1);
    chk("lit_best_fit", int'(best_fitness), 7);
    chk("lit_best_idx", int'(best_index), 1);
    chk("lit_count", int'(eval_count), 4);
    chk("lit_found", int'(gene_found), 0);
    chk("lit_pulses", pulses, 4);
    leave(1'b0);

    // Target hit on the second gene.
    plan(3, 10, 4, 4, 2, 2, 2, 2);
    run_pass(-1, 1'b0);
    chk("lit_found2", int'(gene_found), 1);
    chk("lit_found_idx", int'(found_index), 1);
    chk("lit_best_fit2", int'(best_fitness), 10);
    chk("lit_state_found", int'(state_sched), 6);
    chk("lit_pulses2", pulses, 2);
    leave(1'b0);

    // Gene 2 never answers.
    plan(1, 2, 3, 4, 2, 2, 99, 2);
    run_pass(-1, 1'b0);
    chk("lit_tflag", int'(timeout_flag), 1);
    chk("lit_count3", int'(eval_count), 4);
    chk("lit_best_idx3", int'(best_index), 3);
    leave(1'b0);

    // Deselect during gene 1 WAIT, then reset during gene 1 WAIT.
    plan(3, 7, 5, 2, 2, 2, 2, 2);
    run_pass(6, 1'b0);
    chk("lit_idle_after_drop", int'(state_sched), 0);
    run_pass(6, 1'b1);
    chk("lit_zero_after_rst", int'(best_fitness), 0);

    // Equal fitness keeps the earlier index.
    plan(7, 7, 1, 1, 1, 3, 16, 17);
    run_pass(-1, 1'b0);
    chk("lit_tie_idx", int'(best_index), 0);
    chk("lit_tie_fit", int'(best_fitness), 7);
    leave(1'b0);

    for (int p = 0; p < 40; p++) begin
      int r;
      for (int g = 0; g < POP; g++) begin
        fit[g] = $urandom_range(0, 12);
        lat[g] = $urandom_range(1, 20);
      end
      build();
      r = $urandom_range(0, 7);
      if (r == 0) run_pass($urandom_range(0, tab.size() - 1), 1'b1);
      else if (r <= 2) run_pass($urandom_range(0, tab.size() - 1), 1'b0);
      else begin
        run_pass(-1, 1'b0);
        leave(1'b0);
      end
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fit_scheduler.md
FIT_SCHEDULER -- requirements
Module: fit_scheduler

Interface
REQ-001 Parameter POPULATION, default 24: number of genes evaluated per generation.
REQ-002 Parameter FIT_W, default 10: fitness word width.
REQ-003 Parameter TARGET, default 2: fitness value that marks a solution gene.
REQ-004 Parameter TIMEOUT, default 255: maximum WAIT cycles before an evaluation is abandoned.
REQ-005 Parameter FIT_CTRL, default 3'b001: state_controller code that enables this block.
REQ-006 CLOCK_50  in  1  system clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 state_controller  in  3  top-level controller state; block is active only while equal to FIT_CTRL.
REQ-009 fitness  in  FIT_W  evaluator result; valid only when fitnessReady=1.
REQ-010 fitnessReady  in  1  evaluator result strobe.
REQ-011 eval_start  out  1  one-cycle request to the evaluator.
REQ-012 eval_index  out  8  population index of the gene under evaluation.
REQ-013 best_fitness  out  FIT_W  highest fitness seen this pass.
REQ-014 best_index  out  8  index of best_fitness.
REQ-015 gene_found  out  1  a gene with fitness==TARGET was found.
REQ-016 found_index  out  8  index of that gene.
REQ-017 sched_done  out  1  whole population evaluated without a find.
REQ-018 timeout_flag  out  1  sticky: at least one evaluation timed out this pass.
REQ-019 eval_count  out  8  completed evaluations this pass.
REQ-020 state_sched  out  3  current FSM state.

Function
REQ-021 FSM states and encodings: IDLE 000, ISSUE 001, WAIT 010, CHECK 011, NEXT 100, DONE 101, FOUND 110; unused codes go to IDLE.
REQ-022 IDLE: when state_controller==FIT_CTRL, go to ISSUE; clear eval_index, best_fitness, best_index, eval_count, timeout_flag and the wait timer.
REQ-023 ISSUE: eval_start=1 for exactly this one cycle; clear the wait timer; go to WAIT.
REQ-024 eval_start SHALL be 0 in every state other than ISSUE.
REQ-025 WAIT: when fitnessReady=1, latch fitness into an internal register and go to CHECK.
REQ-026 WAIT timeout: timer increments each cycle without fitnessReady; when timer reaches TIMEOUT-1, latch 0 as the fitness, set timeout_flag and go to CHECK.
REQ-027 fitnessReady outside WAIT SHALL be ignored.
REQ-028 CHECK, latched value==TARGET: set gene_found=1, found_index=eval_index; apply the best update; go to FOUND.
REQ-029 CHECK, otherwise: if latched value > best_fitness (unsigned, strict), update best_fitness/best_index; go to NEXT.
REQ-030 Ties SHALL keep the lower index.
REQ-031 NEXT: increment eval_count. If eval_index==POPULATION-1, go to DONE; else increment eval_index and go to ISSUE. eval_index never wraps.
REQ-032 DONE: sched_done=1; hold the state.
REQ-033 FOUND: gene_found=1; hold the state; issue no further eval_start.
REQ-034 Any state except IDLE: if state_controller!=FIT_CTRL, go to IDLE next cycle and clear gene_found and sched_done; best_*, found_index and eval_count retain their values until the next IDLE exit.
REQ-035 Per-gene minimum latency: ISSUE to next ISSUE = 3 cycles plus the WAIT duration.

Reset
REQ-036 On reset: state IDLE, all outputs 0, internal timer and fitness register 0; reset overrides every other condition in the same cycle.
REQ-037 Reset asserted mid-pass SHALL abandon the pass; no eval_start in the cycle after reset.

Verification (POPULATION=4, TARGET=10, TIMEOUT=16, FIT_CTRL=001)
REQ-038 Fitness sequence 3,7,5,2, each returned 2 cycles after eval_start -> sched_done=1, best_index=1, best_fitness=7, eval_count=4, gene_found=0, exactly 4 eval_start pulses.
REQ-039 Fitness sequence 3,10 -> gene_found=1, found_index=1, best_fitness=10, state FOUND, no eval_start for index 2.
REQ-040 Index 2 never returns fitnessReady -> after 16 WAIT cycles timeout_flag=1 and eval_index=3 is issued; final eval_count=4.
REQ-041 state_controller changed to 000 while in WAIT -> state_sched=000 the next cycle; returning it to 001 restarts at eval_index=0 with best cleared.
REQ-042 Reset pulse during WAIT -> all outputs 0 the next cycle; fitnessReady pulses during ISSUE or CHECK have no effect; fitness sequence 7,7 -> best_index=0.
